mainbus_mem_ctrl: RTL and testbench



---
 rtl/mainbus_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_mainbus_mem_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mainbus_mem_ctrl.sv
// Main-bus memory controller: decodes a page-matched address cycle, then runs
// a fixed-length wrapping burst read or write against a local word memory.
// The shared bus is driven only during this controller's own read data phases.
module mainbus_mem_ctrl #(
    parameter int                DATA_W    = 16,
    parameter int                PAGE_W    = 4,
    parameter logic [PAGE_W-1:0] PAGE_ID   = 4'h2,
    parameter int                BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              addrValid,
    input  logic              rw,
    input  logic [DATA_W-1:0] addrData_in,
    output logic [DATA_W-1:0] addrData_out,
    output logic              addrData_oe,
    output logic              busy
);

    localparam int OFF_W  = DATA_W - PAGE_W;
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int DEPTH  = 1 << OFF_W;

    localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [BEAT_W-1:0]   beat_r;
    logic [OFF_W-1:0]    base_r;
    logic                rw_r;
    logic                start_s;
    logic                last_beat_s;
    logic                wr_en_s;
    logic [OFF_W-1:0]    wr_off_s;
    logic [OFF_W-1:0]    rd_next_off_s;
    logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

    // Offset of a beat: low bits wrap inside the aligned block, upper bits fixed.
    function automatic logic [OFF_W-1:0] beat_offset(input logic [OFF_W-1:0]  base,
                                                     input logic [BEAT_W-1:0] beat);
        logic [BEAT_W-1:0] lo;
        lo = base[BEAT_W-1:0] + beat;
        return {base[OFF_W-1:BEAT_W], lo};
    endfunction

    assign start_s     = addrValid && (addrData_in[DATA_W-1 -: PAGE_W] == PAGE_ID);
    assign last_beat_s = (beat_r == BEAT_LAST);

    // Memory-side strobes: write address of the current beat, read address of the next one.
    always_comb begin
        wr_en_s       = 1'b0;
        wr_off_s      = beat_offset(base_r, beat_r);
        rd_next_off_s = beat_offset(base_r, beat_r + BEAT_ONE);
        if (state_r == BURST) begin
            wr_en_s = !rw_r;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state logic: accept a page hit in IDLE, leave BURST after the last beat.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (last_beat_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = BURST;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst bookkeeping and registered bus outputs; first read word is fetched on the address edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            beat_r       <= BEAT_ZERO;
            base_r       <= {OFF_W{1'b0}};
            rw_r         <= 1'b0;
            busy         <= 1'b0;
            addrData_oe  <= 1'b0;
            addrData_out <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        base_r <= addrData_in[OFF_W-1:0];
                        rw_r   <= rw;
                        beat_r <= BEAT_ZERO;
                        busy   <= 1'b1;
                        if (rw) begin
                            addrData_out <= mem_r[addrData_in[OFF_W-1:0]];
                            addrData_oe  <= 1'b1;
                        end else begin
                            addrData_oe  <= 1'b0;
                        end
                    end else begin
                        busy        <= 1'b0;
                        addrData_oe <= 1'b0;
                    end
                end
                BURST: begin
                    if (last_beat_s) begin
                        beat_r      <= BEAT_ZERO;
                        busy        <= 1'b0;
                        addrData_oe <= 1'b0;
                    end else begin
                        beat_r <= beat_r + BEAT_ONE;
                        if (rw_r) begin
                            addrData_out <= mem_r[rd_next_off_s];
                        end
                    end
                end
                default: begin
                    beat_r      <= BEAT_ZERO;
                    busy        <= 1'b0;
                    addrData_oe <= 1'b0;
                end
            endcase
        end
    end

    // Memory array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_off_s] <= addrData_in;
        end
    end

endmodule

// File: tb/tb_mainbus_mem_ctrl.sv
// Directed, table-driven bench for mainbus_mem_ctrl. Each table row is one bus
// cycle: inputs presented during that cycle and the outputs expected in it.
module tb_mainbus_mem_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        addrValid;
    logic        rw;
    logic [15:0] addrData_in;
    logic [15:0] addrData_out;
    logic        addrData_oe;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        av;
        logic        rw;
        logic [15:0] din;
        logic        chk_out;
        logic [15:0] exp_out;
        logic        exp_oe;
        logic        exp_busy;
        string       name;
    } vec_t;

    vec_t vecs[$];

    mainbus_mem_ctrl #(
        .DATA_W(16), .PAGE_W(4), .PAGE_ID(4'h2), .BURST_LEN(4)
    ) dut (
        .clk(clk), .resetN(resetN), .addrValid(addrValid), .rw(rw),
        .addrData_in(addrData_in), .addrData_out(addrData_out),
        .addrData_oe(addrData_oe), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic av, input logic r, input logic [15:0] din,
                       input logic chk, input logic [15:0] eo, input logic eoe,
                       input logic eb, input string nm);
        vec_t v;
        v.av = av; v.rw = r; v.din = din; v.chk_out = chk;
        v.exp_out = eo; v.exp_oe = eoe; v.exp_busy = eb; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic push_idle(input string nm);
        add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, nm);
    endtask

    task automatic push_write(input string nm, input logic [15:0] addr,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        add(1'b1, 1'b0, addr, 1'b0, 16'h0000, 1'b0, 1'b0, nm);
        add(1'b0, 1'b0, w0, 1'b0, 16'h0000, 1'b0, 1'b1, nm);
        add(1'b0, 1'b0, w1, 1'b0, 16'h0000, 1'b0, 1'b1, nm);
        add(1'b0, 1'b0, w2, 1'b0, 16'h0000, 1'b0, 1'b1, nm);
        add(1'b0, 1'b0, w3, 1'b0, 16'h0000, 1'b0, 1'b1, nm);
    endtask

    task automatic push_read(input string nm, input logic [15:0] addr,
                             input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        add(1'b1, 1'b1, addr, 1'b0, 16'h0000, 1'b0, 1'b0, nm);
        add(1'b0, 1'b1, 16'h0000, 1'b1, e0, 1'b1, 1'b1, nm);
        add(1'b0, 1'b1, 16'h0000, 1'b1, e1, 1'b1, 1'b1, nm);
        add(1'b0, 1'b1, 16'h0000, 1'b1, e2, 1'b1, 1'b1, nm);
        add(1'b0, 1'b1, 16'h0000, 1'b1, e3, 1'b1, 1'b1, nm);
    endtask

    task automatic run_rows();
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            addrValid   = vecs[i].av;
            rw          = vecs[i].rw;
            addrData_in = vecs[i].din;
            check($sformatf("%s[%0d].busy", vecs[i].name, i), {15'd0, busy}, {15'd0, vecs[i].exp_busy});
            check($sformatf("%s[%0d].oe", vecs[i].name, i), {15'd0, addrData_oe}, {15'd0, vecs[i].exp_oe});
            if (vecs[i].chk_out) begin
                check($sformatf("%s[%0d].out", vecs[i].name, i), addrData_out, vecs[i].exp_out);
            end
        end
        vecs.delete();
    endtask

    initial begin
        int base;
        resetN      = 1'b0;
        addrValid   = 1'b0;
        rw          = 1'b0;
        addrData_in = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset.busy", {15'd0, busy}, 16'h0000);
        check("reset.oe", {15'd0, addrData_oe}, 16'h0000);
        check("reset.out", addrData_out, 16'h0000);
        resetN = 1'b1;

        // Basic write then read-back at 0x010..0x013.
        push_write("wr2010", 16'h2010, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
        push_idle("wr2010_end");
        push_read("rd2010", 16'h2010, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
        push_idle("rd2010_end");
        // Known contents at 0x020 block, then a wrapping write at base 0x01E.
        push_write("wr2020", 16'h2020, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
        push_write("wrap", 16'h201E, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        push_idle("wrap_end");
        push_read("rd201C", 16'h201C, 16'h3333, 16'h4444, 16'h1111, 16'h2222);
        push_read("rd2020", 16'h2020, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
        push_idle("rd2020_end");
        // Page miss: no busy, no bus drive, no memory update.
        add(1'b1, 1'b0, 16'h3010, 1'b0, 16'h0000, 1'b0, 1'b0, "miss");
        for (int k = 0; k < 4; k++) begin
            add(1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, "miss");
        end
        push_read("rd_after_miss", 16'h2010, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
        push_idle("miss_end");
        // Ignored addrValid mid-burst, rw toggling mid-burst, then back-to-back read.
        base = vecs.size();
        push_read("b2b_a", 16'h2010, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
        vecs[base + 1].rw  = 1'b0;
        vecs[base + 3].av  = 1'b1;
        vecs[base + 3].din = 16'h201C;
        push_read("b2b_b", 16'h2010, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
        push_idle("b2b_end");
        // Pre-fill 0x040 block for the reset test.
        push_write("wr2040", 16'h2040, 16'hE000, 16'hE001, 16'hE002, 16'hE003);
        push_idle("wr2040_end");
        run_rows();

        // Reset in the middle of a write burst, after beats 0 and 1 are committed.
        @(posedge clk); #1;
        addrValid = 1'b1; rw = 1'b0; addrData_in = 16'h2040;
        @(posedge clk); #1;
        addrValid = 1'b0; addrData_in = 16'hD001;
        check("rstw.busy_c1", {15'd0, busy}, 16'h0001);
        @(posedge clk); #1;
        addrData_in = 16'hD002;
        @(posedge clk); #1;
        addrData_in = 16'hD003;
        check("rstw.busy_c3", {15'd0, busy}, 16'h0001);
        #2;
        resetN = 1'b0;
        #1;
        check("rstw.async_busy", {15'd0, busy}, 16'h0000);
        check("rstw.async_oe", {15'd0, addrData_oe}, 16'h0000);
        check("rstw.async_out", addrData_out, 16'h0000);
        @(posedge clk);
        @(posedge clk); #1;
        check("rstw.held_busy", {15'd0, busy}, 16'h0000);
        addrData_in = 16'h0000;
        resetN = 1'b1;

        // Fresh transaction after release: only 0x040/0x041 were overwritten.
        push_read("rd_after_rst", 16'h2040, 16'hD001, 16'hD002, 16'hE002, 16'hE003);
        push_idle("rd_after_rst_end");
        run_rows();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
